// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the fetch and load/store ports,
// with one outstanding transaction and a watchdog that terminates unacknowledged accesses.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rstn,

    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    output logic        i_err,

    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic [3:0]  d_we,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,

    output logic        m_req,
    output logic [31:0] m_addr,
    output logic [3:0]  m_we,
    output logic [31:0] m_wdata,
    input  logic        m_ack,
    input  logic [31:0] m_rdata,

    output logic        busy
);

    typedef enum logic { ST_IDLE = 1'b0, ST_ACCESS = 1'b1 } state_e;
    typedef enum logic { PORT_I = 1'b0, PORT_D = 1'b1 } port_e;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_e      state_q,       state_d;
    port_e       owner_q,       owner_d;
    port_e       last_served_q, last_served_d;
    logic [7:0]  cnt_q,         cnt_d;
    logic [31:0] m_addr_q,      m_addr_d;
    logic [3:0]  m_we_q,        m_we_d;
    logic [31:0] m_wdata_q,     m_wdata_d;
    logic        i_rvalid_q,    i_rvalid_d;
    logic        i_err_q,       i_err_d;
    logic [31:0] i_rdata_q,     i_rdata_d;
    logic        d_rvalid_q,    d_rvalid_d;
    logic        d_err_q,       d_err_d;
    logic [31:0] d_rdata_q,     d_rdata_d;

    logic        gnt_i;
    logic        gnt_d;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_data;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d       = state_q;
        owner_d       = owner_q;
        last_served_d = last_served_q;
        cnt_d         = cnt_q;
        m_addr_d      = m_addr_q;
        m_we_d        = m_we_q;
        m_wdata_d     = m_wdata_q;
        gnt_i         = 1'b0;
        gnt_d         = 1'b0;
        resp_valid    = 1'b0;
        resp_err      = 1'b0;
        resp_data     = '0;

        case (state_q)
            ST_IDLE: begin
                // On a tie, whichever port was not served last wins.
                gnt_d = d_req && (!i_req || last_served_q == PORT_I);
                gnt_i = i_req && !gnt_d;
                if (gnt_d) begin
                    m_addr_d      = d_addr;
                    m_we_d        = d_we;
                    m_wdata_d     = d_wdata;
                    owner_d       = PORT_D;
                    last_served_d = PORT_D;
                    cnt_d         = '0;
                    state_d       = ST_ACCESS;
                end else if (gnt_i) begin
                    m_addr_d      = i_addr;
                    m_we_d        = '0;
                    m_wdata_d     = '0;
                    owner_d       = PORT_I;
                    last_served_d = PORT_I;
                    cnt_d         = '0;
                    state_d       = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // An ack in the final watchdog cycle still counts as a normal completion.
                if (m_ack) begin
                    resp_valid = 1'b1;
                    resp_data  = (m_we_q != 4'b0000) ? 32'h0 : m_rdata;
                    state_d    = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    resp_valid = 1'b1;
                    resp_err   = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        i_rvalid_d = resp_valid && (owner_q == PORT_I);
        i_err_d    = resp_err   && (owner_q == PORT_I);
        i_rdata_d  = i_rvalid_d ? resp_data : i_rdata_q;
        d_rvalid_d = resp_valid && (owner_q == PORT_D);
        d_err_d    = resp_err   && (owner_q == PORT_D);
        d_rdata_d  = d_rvalid_d ? resp_data : d_rdata_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= ST_IDLE;
            owner_q       <= PORT_I;
            last_served_q <= PORT_I;
            cnt_q         <= '0;
            m_addr_q      <= '0;
            m_we_q        <= '0;
            m_wdata_q     <= '0;
            i_rvalid_q    <= 1'b0;
            i_err_q       <= 1'b0;
            i_rdata_q     <= '0;
            d_rvalid_q    <= 1'b0;
            d_err_q       <= 1'b0;
            d_rdata_q     <= '0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            last_served_q <= last_served_d;
            cnt_q         <= cnt_d;
            m_addr_q      <= m_addr_d;
            m_we_q        <= m_we_d;
            m_wdata_q     <= m_wdata_d;
            i_rvalid_q    <= i_rvalid_d;
            i_err_q       <= i_err_d;
            i_rdata_q     <= i_rdata_d;
            d_rvalid_q    <= d_rvalid_d;
            d_err_q       <= d_err_d;
            d_rdata_q     <= d_rdata_d;
        end
    end

    // Grants are combinational but must stay low for the whole time reset is asserted.
    assign i_gnt    = rstn & gnt_i;
    assign d_gnt    = rstn & gnt_d;

    assign i_rvalid = i_rvalid_q;
    assign i_err    = i_err_q;
    assign i_rdata  = i_rdata_q;
    assign d_rvalid = d_rvalid_q;
    assign d_err    = d_err_q;
    assign d_rdata  = d_rdata_q;

    assign m_req    = (state_q == ST_ACCESS);
    assign m_addr   = m_addr_q;
    assign m_we     = m_we_q;
    assign m_wdata  = m_wdata_q;
    assign busy     = (state_q == ST_ACCESS);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (TIMEOUT=4): fetch, tie alternation, store, timeout,
// ack coincident with timeout, and reset during an access.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_gnt, i_rvalid, i_err;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0;
    logic [31:0] d_addr = '0;
    logic [3:0]  d_we = '0;
    logic [31:0] d_wdata = '0;
    logic        d_gnt, d_rvalid, d_err;
    logic [31:0] d_rdata;
    logic        m_req;
    logic [31:0] m_addr;
    logic [3:0]  m_we;
    logic [31:0] m_wdata;
    logic        m_ack = 1'b0;
    logic [31:0] m_rdata = '0;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    mem_port_arbiter #(.TIMEOUT(4)) dut (
        .clk(clk), .rstn(rstn),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .m_req(m_req), .m_addr(m_addr), .m_we(m_we), .m_wdata(m_wdata),
        .m_ack(m_ack), .m_rdata(m_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are checked 3 units later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 rstn = 1'b0;
        @(posedge clk);
        #3 rstn = 1'b1;
    endtask

    initial begin
        // Reset state, with both requests high to confirm grants are masked.
        i_req = 1'b1;
        d_req = 1'b1;
        #12;
        check("rst_i_gnt", {31'b0, i_gnt}, 32'd0);
        check("rst_d_gnt", {31'b0, d_gnt}, 32'd0);
        check("rst_m_req", {31'b0, m_req}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_m_addr", m_addr, 32'd0);
        check("rst_d_rdata", d_rdata, 32'd0);
        check("rst_i_rvalid", {31'b0, i_rvalid}, 32'd0);
        i_req = 1'b0;
        d_req = 1'b0;
        #1 rstn = 1'b1;

        // Single fetch, ack in the first ACCESS cycle.
        tick();
        i_req = 1'b1; i_addr = 32'h100;
        settle();
        check("f_i_gnt", {31'b0, i_gnt}, 32'd1);
        check("f_d_gnt", {31'b0, d_gnt}, 32'd0);
        tick();
        i_req = 1'b0; m_ack = 1'b1; m_rdata = 32'h0050_0093;
        settle();
        check("f_m_req", {31'b0, m_req}, 32'd1);
        check("f_m_addr", m_addr, 32'h100);
        check("f_m_we", {28'b0, m_we}, 32'd0);
        check("f_busy", {31'b0, busy}, 32'd1);
        tick();
        m_ack = 1'b0;
        settle();
        check("f_i_rvalid", {31'b0, i_rvalid}, 32'd1);
        check("f_i_rdata", i_rdata, 32'h0050_0093);
        check("f_i_err", {31'b0, i_err}, 32'd0);
        check("f_m_req_idle", {31'b0, m_req}, 32'd0);
        tick();
        settle();
        check("f_i_rvalid_pulse", {31'b0, i_rvalid}, 32'd0);
        check("f_i_rdata_hold", i_rdata, 32'h0050_0093);

        // Tie after a fresh reset: D wins, then I in the cycle carrying d_rvalid.
        do_reset();
        tick();
        i_req = 1'b1; i_addr = 32'h200;
        d_req = 1'b1; d_addr = 32'h3000; d_we = 4'b0000;
        settle();
        check("t1_d_gnt", {31'b0, d_gnt}, 32'd1);
        check("t1_i_gnt", {31'b0, i_gnt}, 32'd0);
        tick();
        d_req = 1'b0; m_ack = 1'b1; m_rdata = 32'h1111_2222;
        settle();
        check("t1_m_addr", m_addr, 32'h3000);
        check("t1_no_gnt_access", {31'b0, i_gnt}, 32'd0);
        tick();
        m_ack = 1'b0;
        settle();
        check("t1_d_rvalid", {31'b0, d_rvalid}, 32'd1);
        check("t1_d_rdata", d_rdata, 32'h1111_2222);
        check("t2_i_gnt", {31'b0, i_gnt}, 32'd1);
        tick();
        i_req = 1'b0; m_ack = 1'b1; m_rdata = 32'h3333_4444;
        settle();
        check("t2_m_addr", m_addr, 32'h200);
        tick();
        m_ack = 1'b0;
        i_req = 1'b1; i_addr = 32'h204;
        d_req = 1'b1; d_addr = 32'h3008;
        settle();
        check("t2_i_rvalid", {31'b0, i_rvalid}, 32'd1);
        check("t2_i_rdata", i_rdata, 32'h3333_4444);
        check("t3_d_gnt", {31'b0, d_gnt}, 32'd1);
        check("t3_i_gnt", {31'b0, i_gnt}, 32'd0);
        tick();
        d_req = 1'b0; m_ack = 1'b1; m_rdata = 32'h5555_5555;
        settle();
        check("t3_m_addr", m_addr, 32'h3008);
        tick();
        m_ack = 1'b0;
        settle();
        check("t3_d_rdata", d_rdata, 32'h5555_5555);
        check("t4_i_gnt", {31'b0, i_gnt}, 32'd1);
        tick();
        i_req = 1'b0; m_ack = 1'b1; m_rdata = 32'h6666_7777;
        tick();
        m_ack = 1'b0;
        settle();
        check("t4_i_rdata", i_rdata, 32'h6666_7777);

        // Timeout: read never acknowledged; m_req lasts exactly 4 cycles.
        tick();
        d_req = 1'b1; d_addr = 32'h4000; d_we = 4'b0000;
        settle();
        check("to_d_gnt", {31'b0, d_gnt}, 32'd1);
        for (int c = 0; c < 4; c++) begin
            tick();
            d_req = 1'b0;
            settle();
            check($sformatf("to_m_req_c%0d", c + 1), {31'b0, m_req}, 32'd1);
        end
        tick();
        settle();
        check("to_m_req_drop", {31'b0, m_req}, 32'd0);
        check("to_busy_drop", {31'b0, busy}, 32'd0);
        check("to_d_rvalid", {31'b0, d_rvalid}, 32'd1);
        check("to_d_err", {31'b0, d_err}, 32'd1);
        check("to_d_rdata", d_rdata, 32'd0);
        tick();
        settle();
        check("to_d_err_pulse", {31'b0, d_err}, 32'd0);

        // Store with ack after 3 wait cycles; write data must not reach d_rdata.
        tick();
        d_req = 1'b1; d_addr = 32'h2004; d_we = 4'b0011; d_wdata = 32'hA5A5_1234;
        settle();
        check("st_d_gnt", {31'b0, d_gnt}, 32'd1);
        for (int c = 0; c < 4; c++) begin
            tick();
            d_req = 1'b0; d_we = 4'b0000; d_wdata = 32'h0;
            m_ack = (c == 3);
            m_rdata = 32'hFFFF_FFFF;
            settle();
            check($sformatf("st_m_we_c%0d", c + 1), {28'b0, m_we}, 32'h3);
            check($sformatf("st_m_wdata_c%0d", c + 1), m_wdata, 32'hA5A5_1234);
        end
        check("st_m_addr", m_addr, 32'h2004);
        tick();
        m_ack = 1'b0;
        settle();
        check("st_d_rvalid", {31'b0, d_rvalid}, 32'd1);
        check("st_d_rdata", d_rdata, 32'd0);
        check("st_d_err", {31'b0, d_err}, 32'd0);

        // m_ack seen in IDLE is ignored.
        tick();
        m_ack = 1'b1; m_rdata = 32'h1234_5678;
        tick();
        m_ack = 1'b0;
        settle();
        check("idle_ack_m_req", {31'b0, m_req}, 32'd0);
        check("idle_ack_i_rvalid", {31'b0, i_rvalid}, 32'd0);
        check("idle_ack_d_rvalid", {31'b0, d_rvalid}, 32'd0);

        // Ack coincident with the final watchdog cycle: normal completion.
        tick();
        i_req = 1'b1; i_addr = 32'h500;
        settle();
        check("co_i_gnt", {31'b0, i_gnt}, 32'd1);
        for (int c = 0; c < 4; c++) begin
            tick();
            i_req = 1'b0;
            m_ack = (c == 3);
            m_rdata = 32'hDEAD_BEEF;
        end
        tick();
        m_ack = 1'b0;
        settle();
        check("co_i_rvalid", {31'b0, i_rvalid}, 32'd1);
        check("co_i_err", {31'b0, i_err}, 32'd0);
        check("co_i_rdata", i_rdata, 32'hDEAD_BEEF);

        // Reset during a store wait: outputs drop at once, no response afterwards.
        tick();
        d_req = 1'b1; d_addr = 32'h6000; d_we = 4'b1111; d_wdata = 32'h0BAD_F00D;
        settle();
        check("rm_d_gnt", {31'b0, d_gnt}, 32'd1);
        tick();
        d_req = 1'b0;
        settle();
        check("rm_busy_before", {31'b0, busy}, 32'd1);
        rstn = 1'b0;
        #1;
        check("rm_m_req_async", {31'b0, m_req}, 32'd0);
        check("rm_busy_async", {31'b0, busy}, 32'd0);
        tick();
        settle();
        rstn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            m_ack = (c == 0);
            settle();
            check($sformatf("rm_no_d_rvalid_%0d", c), {31'b0, d_rvalid}, 32'd0);
            check($sformatf("rm_no_m_req_%0d", c), {31'b0, m_req}, 32'd0);
        end
        tick();
        m_ack = 1'b0;
        i_req = 1'b1; i_addr = 32'h700;
        d_req = 1'b1; d_addr = 32'h7000; d_we = 4'b0000;
        settle();
        check("rm_tie_d_gnt", {31'b0, d_gnt}, 32'd1);
        check("rm_tie_i_gnt", {31'b0, i_gnt}, 32'd0);
        tick();
        i_req = 1'b0; d_req = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
